// File: rtl/seg_scan_ctrl_pkg.sv
// seg_pkg: shared constants for the seven-segment scan controller.
//   HEX_SEG   : 16-entry hex-to-segment table, active-low {g,f,e,d,c,b,a}
//   SEG_BLANK : all segments off
//   AN_OFF    : all anodes off
//   N_DIGITS  : number of scanned digits
//   hex_to_seg: table lookup helper
package seg_pkg;

    localparam int N_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Index 15 is leftmost in the concatenation, index 0 rightmost.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: display-value and display-pin bundle.
//   data/load        : word to show and its capture strobe (producer side)
//   en_mask/dp_mask  : live per-digit enable and decimal point
//   an/seg/dp        : active-low display pins
//   digit_idx        : current scan index
//   frame_done       : one-cycle pulse after a frame wrap
// master = value producer / pin consumer, slave = the scan controller.
interface seg_scan_ctrl_if;
    logic [31:0] data;
    logic        load;
    logic [7:0]  en_mask;
    logic [7:0]  dp_mask;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [2:0]  digit_idx;
    logic        frame_done;

    modport master (
        output data, load, en_mask, dp_mask,
        input  an, seg, dp, digit_idx, frame_done
    );

    modport slave (
        input  data, load, en_mask, dp_mask,
        output an, seg, dp, digit_idx, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl_hex7seg.sv
// hex7seg: combinational hex nibble to active-low seven-segment pattern.
//   nib : 4-bit hex value
//   seg : {g,f,e,d,c,b,a}, active-low
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nib);

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 8-digit seven-segment driver.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of seg_scan_ctrl_if (data/load in, masks in,
//                an/seg/dp/digit_idx/frame_done out)
// A prescaler steps the digit index every CLK_DIV cycles. Loaded words wait
// in a shadow register and move to the display register only on the 7->0
// wrap, so a frame is never drawn from two different words.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_DIV = 100000
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scan_ctrl_if.slave bus
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       digit_idx;
    logic [31:0]      shadow;
    logic             pending;
    logic [31:0]      disp;
    logic             frame_done;
    logic [7:0]       an_q;
    logic [6:0]       seg_q;
    logic             dp_q;

    logic             tick;
    logic             wrap;
    logic [3:0]       cur_nib;
    logic [6:0]       cur_seg;
    logic             cur_en;

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign wrap = tick && (digit_idx == 3'd7);

    assign cur_nib = disp[{digit_idx, 2'b00} +: 4];
    assign cur_en  = bus.en_mask[digit_idx];

    hex7seg u_hex7seg (
        .nib (cur_nib),
        .seg (cur_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            digit_idx  <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            disp       <= '0;
            frame_done <= 1'b0;
            an_q       <= AN_OFF;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                digit_idx <= digit_idx + 3'd1;

            if (bus.load)
                shadow <= bus.data;

            // A load landing on the wrap itself bypasses the shadow so it is
            // not deferred a whole frame.
            if (wrap) begin
                if (bus.load)
                    disp <= bus.data;
                else if (pending)
                    disp <= shadow;
                pending <= 1'b0;
            end else if (bus.load) begin
                pending <= 1'b1;
            end

            frame_done <= wrap;

            // Outputs follow the index one cycle late; the old anode stays on
            // for that cycle.
            an_q  <= cur_en ? ~(8'h01 << digit_idx) : AN_OFF;
            seg_q <= cur_en ? cur_seg : SEG_BLANK;
            dp_q  <= ~(cur_en & bus.dp_mask[digit_idx]);
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.digit_idx  = digit_idx;
    assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed self-checking bench for seg_scan_ctrl, CLK_DIV=4.
module tb_seg_scan_ctrl;

    localparam int DIV = 4;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } dig_vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   k;

    logic [6:0] hexpat [16];
    dig_vec_t   mvec [8];

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(.CLK_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s k=%0d got=%h want=%h", nm, k, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        k++;
    endtask

    // Run n cycles with all digits enabled, no dp, checking the scan pattern
    // of the given displayed word and the frame pulse.
    task automatic run_word(input int n, input logic [31:0] word, input string nm);
        for (int i = 0; i < n; i++) begin
            int d;
            logic [7:0] exp_an;
            cyc();
            d = ((k - 1) / DIV) % 8;
            exp_an = ~(8'h01 << d);
            chk({nm, "_an"}, 32'(bus.an), 32'(exp_an));
            chk({nm, "_seg"}, 32'(bus.seg), 32'(hexpat[word[d*4 +: 4]]));
            chk({nm, "_dp"}, 32'(bus.dp), 32'd1);
            chk({nm, "_fd"}, 32'(bus.frame_done), (k % 32 == 0) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        k     = 0;

        hexpat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        // Mask scenario with disp = AAAAAAAA, en_mask=0F, dp_mask=05.
        mvec[0] = '{an: 8'hFE, seg: 7'h08, dp: 1'b0};
        mvec[1] = '{an: 8'hFD, seg: 7'h08, dp: 1'b1};
        mvec[2] = '{an: 8'hFB, seg: 7'h08, dp: 1'b0};
        mvec[3] = '{an: 8'hF7, seg: 7'h08, dp: 1'b1};
        mvec[4] = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1};
        mvec[5] = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1};
        mvec[6] = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1};
        mvec[7] = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1};

        // Reset, with a load held during reset that must be ignored.
        rst_n       = 1'b0;
        bus.load    = 1'b1;
        bus.data    = 32'hFFFF_FFFF;
        bus.en_mask = 8'hFF;
        bus.dp_mask = 8'h00;
        cyc();
        cyc();
        chk("rst_an", 32'(bus.an), 32'hFF);
        chk("rst_seg", 32'(bus.seg), 32'h7F);
        chk("rst_dp", 32'(bus.dp), 32'd1);
        chk("rst_idx", 32'(bus.digit_idx), 32'd0);
        chk("rst_fd", 32'(bus.frame_done), 32'd0);
        bus.load = 1'b0;
        bus.data = 32'h0;
        rst_n    = 1'b1;
        k        = 0;

        // Free scan of zeros, covering one wrap.
        run_word(40, 32'h0, "scan0");

        // Load mid-frame at digit 3; current frame keeps showing zeros.
        run_word(5, 32'h0, "pre_ld");
        chk("idx_at_load", 32'(bus.digit_idx), 32'd3);
        bus.load = 1'b1;
        bus.data = 32'h7654_3210;
        run_word(1, 32'h0, "ld1");
        bus.load = 1'b0;
        chk("pend_set", 32'(dut.pending), 32'd1);
        run_word(18, 32'h0, "old_frame");
        run_word(32, 32'h7654_3210, "new_frame");

        // Two loads in one frame; only the last is shown.
        run_word(1, 32'h7654_3210, "hold_a");
        bus.load = 1'b1;
        bus.data = 32'h1111_1111;
        run_word(1, 32'h7654_3210, "ld_ones");
        bus.load = 1'b0;
        run_word(11, 32'h7654_3210, "hold_b");
        bus.load = 1'b1;
        bus.data = 32'hFEDC_BA98;
        run_word(1, 32'h7654_3210, "ld_fedc");
        bus.load = 1'b0;
        run_word(18, 32'h7654_3210, "hold_c");
        run_word(31, 32'hFEDC_BA98, "last_wins");

        // Load exactly on the wrap-tick cycle (edge 160).
        bus.load = 1'b1;
        bus.data = 32'hAAAA_AAAA;
        run_word(1, 32'hFEDC_BA98, "wrap_ld");
        bus.load = 1'b0;
        chk("wrap_pend", 32'(dut.pending), 32'd0);
        run_word(32, 32'hAAAA_AAAA, "bypass");
        chk("bypass_pend", 32'(dut.pending), 32'd0);

        // Masks: live, table driven per digit.
        bus.en_mask = 8'h0F;
        bus.dp_mask = 8'h05;
        for (int i = 0; i < 32; i++) begin
            int d;
            cyc();
            d = ((k - 1) / DIV) % 8;
            chk("mask_an", 32'(bus.an), 32'(mvec[d].an));
            chk("mask_seg", 32'(bus.seg), 32'(mvec[d].seg));
            chk("mask_dp", 32'(bus.dp), 32'(mvec[d].dp));
        end
        bus.en_mask = 8'hFF;
        bus.dp_mask = 8'h00;

        // Reset mid-frame with a word pending.
        run_word(5, 32'hAAAA_AAAA, "pre_rst");
        bus.load = 1'b1;
        bus.data = 32'h1234_5678;
        run_word(1, 32'hAAAA_AAAA, "ld_prst");
        bus.load = 1'b0;
        run_word(5, 32'hAAAA_AAAA, "pend_wait");
        chk("pend_before_rst", 32'(dut.pending), 32'd1);
        rst_n    = 1'b0;
        bus.load = 1'b1;
        bus.data = 32'hDEAD_BEEF;
        cyc();
        chk("mrst_an", 32'(bus.an), 32'hFF);
        chk("mrst_idx", 32'(bus.digit_idx), 32'd0);
        chk("mrst_disp", dut.disp, 32'h0);
        chk("mrst_pend", 32'(dut.pending), 32'd0);
        chk("mrst_fd", 32'(bus.frame_done), 32'd0);
        rst_n    = 1'b1;
        bus.load = 1'b0;
        k        = 0;
        run_word(40, 32'h0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
